uart_out_arbiter: RTL and testbench
===================================

UART_OUT_ARBITER -- requirements
Module: uart_out_arbiter

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 255, meaning consecutive uart_out_full cycles in SEND before stall_err pulses (range 1..65535).
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port n_reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port src_msg0/1/2, input, `UART_MSG_WIDTH each, message offered by source 0/1/2.
REQ-005 SHALL have port src_valid, input, 3, bit i high means src_msg<i> is offered.
REQ-006 SHALL have port src_ack, output, 3, one-cycle pulse on bit i when src_msg<i> is captured.
REQ-007 SHALL have port uart_out_full, input, 1, output FIFO full.
REQ-008 SHALL have port uart_out_msg, output, `UART_MSG_WIDTH, message to the output FIFO.
REQ-009 SHALL have port uart_out_req, output, 1, one-cycle FIFO write strobe.
REQ-010 SHALL have port stall_err, output, 1, one-cycle pulse on output stall timeout.
REQ-011 SHALL have port msgs_sent, output, 16, count of uart_out_req pulses.

Function
REQ-012 States SHALL be IDLE, GRANT and SEND, all transitions on posedge clk.
REQ-013 In IDLE with src_valid != 0: register the winner index, capture its message into uart_out_msg, go to GRANT; otherwise stay in IDLE.
REQ-014 In GRANT: src_ack[winner] SHALL be 1 for exactly this cycle, then go to SEND.
REQ-015 A source SHALL drop valid, or present its next message, in the cycle after its ack; the arbiter SHALL ignore src_valid in GRANT and SEND.
REQ-016 In SEND with uart_out_full=0: uart_out_req SHALL be 1 for exactly this cycle with uart_out_msg stable, then go to IDLE.
REQ-017 In SEND with uart_out_full=1: stay in SEND, uart_out_req=0, increment the stall counter.
REQ-018 When the stall counter reaches STALL_LIMIT, stall_err SHALL pulse once; the counter SHALL saturate and the block keeps waiting without dropping the message.
REQ-019 The stall counter SHALL clear on every entry to SEND.
REQ-020 uart_out_msg SHALL change only in IDLE on a capture.
REQ-021 msgs_sent SHALL increment on each uart_out_req pulse and wrap from 0xFFFF to 0.
REQ-022 Minimum throughput SHALL be 1 message per 3 cycles: capture to req in 2 cycles when the FIFO is not full.
REQ-023 src_ack SHALL be one-hot or zero; uart_out_req and src_ack SHALL never be high in the same cycle.

Reset
REQ-024 While n_reset=0, independent of clk: state=IDLE, uart_out_msg=0, uart_out_req=0, src_ack=0, stall_err=0, msgs_sent=0, stall counter=0, last-grant pointer=2.
REQ-025 Reset asserted in GRANT or SEND SHALL discard the captured message, with no ack and no req issued after reset.

Configuration
REQ-026 With UART_ARB_ROUND_ROBIN_EN defined: the winner SHALL be the first valid source searching upward, with wrap, from last-grant+1; last-grant updates on each capture.
REQ-027 Without UART_ARB_ROUND_ROBIN_EN: fixed priority SHALL apply, src0 > src1 > src2, with the last-grant pointer unused.

Verification
REQ-028 Single source: valid=3'b010, msg1 low byte 0x22, FIFO not full -> ack=3'b010 in cycle 2, req with msg 0x22 in cycle 3, msgs_sent=1.
REQ-029 All three held valid with RR enabled, after reset -> grants 0,1,2,0 in order; with macro undefined and src0 re-asserting after ack -> src0 granted every time.
REQ-030 uart_out_full high for 300 cycles in SEND with STALL_LIMIT=255 -> exactly one stall_err pulse at the 255th full cycle; req issued in the first cycle full drops, message unchanged.
REQ-031 n_reset pulsed low while in SEND with full=1 -> all outputs zero immediately, no req afterwards, next capture starts at src0.
REQ-032 msgs_sent preloaded by 65535 sends, then one more send -> msgs_sent=0.
REQ-033 src_valid toggled during GRANT/SEND -> no extra ack, and uart_out_msg stable until the next IDLE capture.

Source files
------------

// File: rtl/uart_out_arbiter.sv
// -----------------------------------------------------------------------------
// uart_out_arbiter
//
// Purpose:
//   Arbitrates three message sources onto a single UART output FIFO write
//   port. A three-state FSM (IDLE -> GRANT -> SEND) captures one message,
//   acknowledges its source, then writes it into the FIFO as soon as the FIFO
//   is not full. A stall watchdog pulses stall_err once if the FIFO stays full
//   for STALL_LIMIT consecutive SEND cycles; the message is never dropped.
//
// Configuration:
//   UART_ARB_ROUND_ROBIN_EN  - when defined, round-robin arbitration starting
//                              after the last granted source; when undefined,
//                              fixed priority src0 > src1 > src2.
//   UART_MSG_WIDTH           - message width in bits (defaults to 8).
//
// Parameters:
//   STALL_LIMIT    consecutive full cycles in SEND before stall_err (1..65535)
//
// Ports:
//   clk            system clock
//   n_reset        asynchronous active-low reset
//   src_msg0/1/2   message offered by source 0/1/2
//   src_valid      bit i high: src_msg<i> is offered
//   src_ack        one-cycle pulse on bit i when src_msg<i> was captured
//   uart_out_full  output FIFO full
//   uart_out_msg   message presented to the output FIFO
//   uart_out_req   one-cycle FIFO write strobe
//   stall_err      one-cycle pulse on output stall timeout
//   msgs_sent      wrapping count of uart_out_req pulses
// -----------------------------------------------------------------------------
`ifndef UART_MSG_WIDTH
`define UART_MSG_WIDTH 8
`endif

module uart_out_arbiter #(
    parameter int STALL_LIMIT = 255
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic [`UART_MSG_WIDTH-1:0] src_msg0,
    input  logic [`UART_MSG_WIDTH-1:0] src_msg1,
    input  logic [`UART_MSG_WIDTH-1:0] src_msg2,
    input  logic [2:0]                 src_valid,
    output logic [2:0]                 src_ack,
    input  logic                       uart_out_full,
    output logic [`UART_MSG_WIDTH-1:0] uart_out_msg,
    output logic                       uart_out_req,
    output logic                       stall_err,
    output logic [15:0]                msgs_sent
);

    localparam int MSG_W = `UART_MSG_WIDTH;

    // Saturation value of the stall counter and the value it holds during the
    // full cycle that reaches the limit (that cycle raises stall_err).
    localparam logic [15:0] STALL_MAX = 16'(STALL_LIMIT);
    localparam logic [15:0] STALL_PRE = 16'(STALL_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [1:0]         winner_reg;
    logic [1:0]         winner_next;
    logic [MSG_W-1:0]   msg_reg;
    logic [MSG_W-1:0]   msg_next;
    logic [15:0]        stall_cnt_reg;
    logic [15:0]        sent_cnt_reg;
    logic               capture;
    logic               req_int;

    // A capture happens only in IDLE; src_valid is ignored in GRANT and SEND.
    assign capture = (state_reg == IDLE) && (src_valid != 3'b000);

    // -------------------------------------------------------------------------
    // Winner selection
    // -------------------------------------------------------------------------
`ifdef UART_ARB_ROUND_ROBIN_EN
    // Index of the most recently granted source; resets to 2 so that the
    // first search after reset begins at source 0.
    logic [1:0] last_grant_reg;
    logic [1:0] cand;
    logic       found;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Search upward with wrap, starting one past the last grant.
    always_comb begin
        winner_next = 2'd0;
        found       = 1'b0;
        cand        = next_idx(last_grant_reg);
        for (int k = 0; k < 3; k++) begin
            if (!found && src_valid[cand]) begin
                winner_next = cand;
                found       = 1'b1;
            end
            cand = next_idx(cand);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            last_grant_reg <= 2'd2;
        end else if (capture) begin
            last_grant_reg <= winner_next;
        end
    end
`else
    // Fixed priority: lowest index wins.
    always_comb begin
        if (src_valid[0]) begin
            winner_next = 2'd0;
        end else if (src_valid[1]) begin
            winner_next = 2'd1;
        end else begin
            winner_next = 2'd2;
        end
    end
`endif

    // Message of the selected source.
    always_comb begin
        case (winner_next)
            2'd0:    msg_next = src_msg0;
            2'd1:    msg_next = src_msg1;
            default: msg_next = src_msg2;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (capture) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                state_next = SEND;
            end
            SEND: begin
                // Wait indefinitely while the FIFO is full; the message is
                // held, never dropped.
                if (!uart_out_full) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        req_int   = 1'b0;
        stall_err = 1'b0;
        if (state_reg == SEND) begin
            req_int   = !uart_out_full;
            // Pulses in the full cycle that brings the counter to the limit;
            // afterwards the counter sits saturated and never matches again.
            stall_err = uart_out_full && (stall_cnt_reg == STALL_PRE);
        end
    end

    // Ack is decoded from the registered winner; GRANT lasts exactly one
    // cycle so each bit is a single-cycle, one-hot pulse.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ack
            assign src_ack[gi] = (state_reg == GRANT) && (winner_reg == 2'(gi));
        end
    endgenerate

    assign uart_out_req = req_int;
    assign uart_out_msg = msg_reg;
    assign msgs_sent    = sent_cnt_reg;

    // -------------------------------------------------------------------------
    // Datapath: captured message, winner, stall watchdog, send counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            msg_reg       <= '0;
            winner_reg    <= 2'd0;
            stall_cnt_reg <= 16'd0;
            sent_cnt_reg  <= 16'd0;
        end else begin
            // The output message only ever changes on an IDLE capture.
            if (capture) begin
                msg_reg    <= msg_next;
                winner_reg <= winner_next;
            end

            // GRANT is the only way into SEND, so clearing here clears the
            // watchdog on every entry to SEND.
            if (state_reg == GRANT) begin
                stall_cnt_reg <= 16'd0;
            end else if ((state_reg == SEND) && uart_out_full &&
                         (stall_cnt_reg != STALL_MAX)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end

            // Natural 16-bit wrap from 0xFFFF to 0.
            if (req_int) begin
                sent_cnt_reg <= sent_cnt_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_out_arbiter.sv
`ifndef UART_MSG_WIDTH
`define UART_MSG_WIDTH 8
`endif

module tb_uart_out_arbiter;

    localparam int MSG_W = `UART_MSG_WIDTH;

    logic             clk;
    logic             n_reset;
    logic [MSG_W-1:0] src_msg0;
    logic [MSG_W-1:0] src_msg1;
    logic [MSG_W-1:0] src_msg2;
    logic [2:0]       src_valid;
    logic [2:0]       src_ack;
    logic             uart_out_full;
    logic [MSG_W-1:0] uart_out_msg;
    logic             uart_out_req;
    logic             stall_err;
    logic [15:0]      msgs_sent;

    uart_out_arbiter #(.STALL_LIMIT(255)) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .src_msg0      (src_msg0),
        .src_msg1      (src_msg1),
        .src_msg2      (src_msg2),
        .src_valid     (src_valid),
        .src_ack       (src_ack),
        .uart_out_full (uart_out_full),
        .uart_out_msg  (uart_out_msg),
        .uart_out_req  (uart_out_req),
        .stall_err     (stall_err),
        .msgs_sent     (msgs_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: expected grants (source index + message) in order.
    typedef struct packed {
        logic [1:0]       src;
        logic [MSG_W-1:0] msg;
    } exp_t;

    exp_t             exp_q[$];
    logic [MSG_W-1:0] pend_msg;
    bit               pend_valid;
    int               ack_seen;
    int               req_seen;
    logic [15:0]      exp_sent;
    int               checks;
    int               failures;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (n_reset) begin
            if (src_ack != 3'b000) begin
                check_val("ack_onehot", $countones(src_ack), 1);
                check_val("ack_req_excl", {31'd0, uart_out_req}, 0);
                if (exp_q.size() == 0) begin
                    check_val("ack_unexpected", {29'd0, src_ack}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("ack_src", {29'd0, src_ack}, 32'd1 << e.src);
                    check_val("ack_msg", 32'(uart_out_msg), 32'(e.msg));
                    pend_msg   = e.msg;
                    pend_valid = 1'b1;
                end
                ack_seen++;
            end
            if (uart_out_req) begin
                if (!pend_valid) begin
                    check_val("req_unexpected", {31'd0, uart_out_req}, 0);
                end else begin
                    check_val("req_msg", 32'(uart_out_msg), 32'(pend_msg));
                    pend_valid = 1'b0;
                end
                $display("txn: req msg=0x%0h msgs_sent_before=%0d", uart_out_msg, msgs_sent);
                exp_sent++;
                req_seen++;
            end
        end
    end

    task automatic do_reset();
        n_reset       = 1'b0;
        src_valid     = 3'b000;
        uart_out_full = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        exp_q.delete();
        pend_valid = 1'b0;
        exp_sent   = 16'd0;
        n_reset    = 1'b1;
    endtask

    // Returns on the rising edge that follows the target ack (start of SEND).
    task automatic wait_ack(input int target);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (ack_seen >= target) return;
        end
        check_val("ack_timeout", ack_seen, target);
    endtask

    task automatic wait_req(input int target);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (req_seen >= target) return;
        end
        check_val("req_timeout", req_seen, target);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_msg"}, 32'(uart_out_msg), 0);
        check_val({tag, "_req"}, {31'd0, uart_out_req}, 0);
        check_val({tag, "_ack"}, {29'd0, src_ack}, 0);
        check_val({tag, "_stall"}, {31'd0, stall_err}, 0);
        check_val({tag, "_sent"}, {16'd0, msgs_sent}, 0);
    endtask

    // Offer one message from a single source and let it complete.
    task automatic single_send(input int src, input logic [MSG_W-1:0] m);
        int base;
        base = req_seen;
        @(posedge clk);
        #2;
        case (src)
            0:       src_msg0 = m;
            1:       src_msg1 = m;
            default: src_msg2 = m;
        endcase
        exp_q.push_back('{src: 2'(src), msg: m});
        src_valid = 3'b001 << src;
        wait_ack(ack_seen + 1);
        #2;
        src_valid = 3'b000;
        wait_req(base + 1);
    endtask

    initial begin
        int base;
        int stall_pulses;
        int stall_at;
        int req_in_stall;

        checks     = 0;
        failures   = 0;
        ack_seen   = 0;
        req_seen   = 0;
        pend_valid = 1'b0;
        exp_sent   = 16'd0;
        src_msg0   = '0;
        src_msg1   = '0;
        src_msg2   = '0;

        // ---- Reset state ------------------------------------------------
        n_reset       = 1'b0;
        src_valid     = 3'b111;
        uart_out_full = 1'b0;
        #1;
        check_all_zero("rst_async");
        do_reset();

        // ---- Single source, cycle-accurate latency -----------------------
        @(posedge clk);
        #2;
        src_msg1  = 8'h22;
        src_valid = 3'b010;
        exp_q.push_back('{src: 2'd1, msg: 8'h22});
        @(negedge clk);
        check_val("lat_c1_ack", {29'd0, src_ack}, 0);
        @(negedge clk);
        check_val("lat_c2_ack", {29'd0, src_ack}, 32'h2);
        @(posedge clk);
        #2;
        src_valid = 3'b000;
        @(negedge clk);
        check_val("lat_c3_req", {31'd0, uart_out_req}, 1);
        check_val("lat_c3_msg", 32'(uart_out_msg), 32'h22);
        @(negedge clk);
        check_val("lat_sent", {16'd0, msgs_sent}, 1);

        // ---- All three valid after reset ----------------------------------
        do_reset();
        src_msg0 = 8'hA0;
        src_msg1 = 8'hA1;
        src_msg2 = 8'hA2;
`ifdef UART_ARB_ROUND_ROBIN_EN
        exp_q.push_back('{src: 2'd0, msg: 8'hA0});
        exp_q.push_back('{src: 2'd1, msg: 8'hA1});
        exp_q.push_back('{src: 2'd2, msg: 8'hA2});
        exp_q.push_back('{src: 2'd0, msg: 8'hA0});
`else
        repeat (4) exp_q.push_back('{src: 2'd0, msg: 8'hA0});
`endif
        base = req_seen;
        @(posedge clk);
        #2;
        src_valid = 3'b111;
        wait_ack(ack_seen + 4);
        #2;
        src_valid = 3'b000;
        wait_req(base + 4);
        @(negedge clk);
        check_val("multi_sent", {16'd0, msgs_sent}, {16'd0, exp_sent});
        check_val("multi_cnt", {16'd0, msgs_sent}, 4);

        // src1+src2 offered: both schemes pick src1 (RR last grant was 0)
        base = req_seen;
        exp_q.push_back('{src: 2'd1, msg: 8'hA1});
        @(posedge clk);
        #2;
        src_valid = 3'b110;
        wait_ack(ack_seen + 1);
        #2;
        src_valid = 3'b000;
        wait_req(base + 1);

        // src0+src2 offered: fixed picks 0, RR (last grant 1) picks 2
        base = req_seen;
`ifdef UART_ARB_ROUND_ROBIN_EN
        exp_q.push_back('{src: 2'd2, msg: 8'hA2});
`else
        exp_q.push_back('{src: 2'd0, msg: 8'hA0});
`endif
        @(posedge clk);
        #2;
        src_valid = 3'b101;
        wait_ack(ack_seen + 1);
        #2;
        src_valid = 3'b000;
        wait_req(base + 1);

        // ---- Stall watchdog: FIFO full for 300 SEND cycles ----------------
        base          = req_seen;
        stall_pulses  = 0;
        stall_at      = 0;
        req_in_stall  = 0;
        @(posedge clk);
        #2;
        uart_out_full = 1'b1;
        src_msg2      = 8'h5C;
        src_valid     = 3'b100;
        exp_q.push_back('{src: 2'd2, msg: 8'h5C});
        wait_ack(ack_seen + 1);
        #2;
        src_valid = 3'b000;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (stall_err) begin
                stall_pulses++;
                stall_at = k;
            end
            if (uart_out_req) req_in_stall++;
        end
        check_val("stall_pulses", stall_pulses, 1);
        check_val("stall_cycle", stall_at, 255);
        check_val("stall_no_req", req_in_stall, 0);
        check_val("stall_msg", 32'(uart_out_msg), 32'h5C);
        @(posedge clk);
        #2;
        uart_out_full = 1'b0;
        @(negedge clk);
        check_val("stall_release_req", {31'd0, uart_out_req}, 1);
        check_val("stall_release_msg", 32'(uart_out_msg), 32'h5C);
        check_val("stall_release_err", {31'd0, stall_err}, 0);

        // ---- Reset while stalled in SEND ----------------------------------
        @(posedge clk);
        #2;
        uart_out_full = 1'b1;
        src_msg1      = 8'h77;
        src_valid     = 3'b010;
        exp_q.push_back('{src: 2'd1, msg: 8'h77});
        wait_ack(ack_seen + 1);
        #2;
        src_valid = 3'b000;
        repeat (3) @(posedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        check_all_zero("rst_in_send");
        @(posedge clk);
        #2;
        exp_q.delete();
        pend_valid    = 1'b0;
        exp_sent      = 16'd0;
        uart_out_full = 1'b0;
        n_reset       = 1'b1;
        base          = req_seen;
        repeat (8) @(negedge clk);
        check_val("rst_no_req", req_seen, base);
        check_val("rst_sent", {16'd0, msgs_sent}, 0);
        src_msg0 = 8'h31;
        src_msg1 = 8'h32;
        src_msg2 = 8'h33;
        exp_q.push_back('{src: 2'd0, msg: 8'h31});
        @(posedge clk);
        #2;
        src_valid = 3'b111;
        wait_ack(ack_seen + 1);
        #2;
        src_valid = 3'b000;
        wait_req(base + 1);

        // ---- msgs_sent wrap ----------------------------------------------
        @(posedge clk);
        #2;
        force dut.sent_cnt_reg = 16'hFFFF;
        #1;
        release dut.sent_cnt_reg;
        exp_sent = 16'hFFFF;
        @(negedge clk);
        check_val("wrap_pre", {16'd0, msgs_sent}, 32'hFFFF);
        single_send(2, 8'h99);
        @(negedge clk);
        check_val("wrap_post", {16'd0, msgs_sent}, 0);
        check_val("wrap_model", {16'd0, msgs_sent}, {16'd0, exp_sent});

        // ---- src_valid toggling during GRANT/SEND -------------------------
        @(posedge clk);
        #2;
        src_msg2  = 8'h4D;
        src_valid = 3'b100;
        exp_q.push_back('{src: 2'd2, msg: 8'h4D});
        @(posedge clk);
        #2;
        src_valid = 3'b011;
        src_msg0  = 8'hEE;
        @(negedge clk);
        check_val("tog_grant_ack", {29'd0, src_ack}, 32'h4);
        check_val("tog_grant_msg", 32'(uart_out_msg), 32'h4D);
        @(posedge clk);
        #2;
        src_valid = 3'b111;
        @(negedge clk);
        check_val("tog_send_ack", {29'd0, src_ack}, 0);
        check_val("tog_send_req", {31'd0, uart_out_req}, 1);
        check_val("tog_send_msg", 32'(uart_out_msg), 32'h4D);
        @(posedge clk);
        #2;
        src_valid = 3'b000;
        repeat (4) @(negedge clk);
        check_val("tog_msg_hold", 32'(uart_out_msg), 32'h4D);

        check_val("sb_empty", exp_q.size(), 0);
        check_val("sb_pending", {31'd0, pend_valid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
